// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control-strobe indices, opcode constants, state and class encodings
package cpu_ctrl_pkg;

   // Width of the control strobe bus; bit 0 is PCout, bit 21 is Write
   localparam int CTRL_W = 22;

   // Control strobe bit indices
   localparam int C_PCOUT    = 0;
   localparam int C_PCIN     = 1;
   localparam int C_INCPC    = 2;
   localparam int C_MARIN    = 3;
   localparam int C_MDRIN    = 4;
   localparam int C_MDROUT   = 5;
   localparam int C_IRIN     = 6;
   localparam int C_YIN      = 7;
   localparam int C_ZIN      = 8;
   localparam int C_ZLOWOUT  = 9;
   localparam int C_ZHIGHOUT = 10;
   localparam int C_HIIN     = 11;
   localparam int C_LOIN     = 12;
   localparam int C_GRA      = 13;
   localparam int C_GRB      = 14;
   localparam int C_GRC      = 15;
   localparam int C_RIN      = 16;
   localparam int C_ROUT     = 17;
   localparam int C_BAOUT    = 18;
   localparam int C_COUT     = 19;
   localparam int C_READ     = 20;
   localparam int C_WRITE    = 21;

   // One-hot masks so strobe sets can be OR-ed together
   localparam logic [CTRL_W-1:0] M_PCOUT    = CTRL_W'(1) << C_PCOUT;
   localparam logic [CTRL_W-1:0] M_PCIN     = CTRL_W'(1) << C_PCIN;
   localparam logic [CTRL_W-1:0] M_INCPC    = CTRL_W'(1) << C_INCPC;
   localparam logic [CTRL_W-1:0] M_MARIN    = CTRL_W'(1) << C_MARIN;
   localparam logic [CTRL_W-1:0] M_MDRIN    = CTRL_W'(1) << C_MDRIN;
   localparam logic [CTRL_W-1:0] M_MDROUT   = CTRL_W'(1) << C_MDROUT;
   localparam logic [CTRL_W-1:0] M_IRIN     = CTRL_W'(1) << C_IRIN;
   localparam logic [CTRL_W-1:0] M_YIN      = CTRL_W'(1) << C_YIN;
   localparam logic [CTRL_W-1:0] M_ZIN      = CTRL_W'(1) << C_ZIN;
   localparam logic [CTRL_W-1:0] M_ZLOWOUT  = CTRL_W'(1) << C_ZLOWOUT;
   localparam logic [CTRL_W-1:0] M_ZHIGHOUT = CTRL_W'(1) << C_ZHIGHOUT;
   localparam logic [CTRL_W-1:0] M_HIIN     = CTRL_W'(1) << C_HIIN;
   localparam logic [CTRL_W-1:0] M_LOIN     = CTRL_W'(1) << C_LOIN;
   localparam logic [CTRL_W-1:0] M_GRA      = CTRL_W'(1) << C_GRA;
   localparam logic [CTRL_W-1:0] M_GRB      = CTRL_W'(1) << C_GRB;
   localparam logic [CTRL_W-1:0] M_GRC      = CTRL_W'(1) << C_GRC;
   localparam logic [CTRL_W-1:0] M_RIN      = CTRL_W'(1) << C_RIN;
   localparam logic [CTRL_W-1:0] M_ROUT     = CTRL_W'(1) << C_ROUT;
   localparam logic [CTRL_W-1:0] M_BAOUT    = CTRL_W'(1) << C_BAOUT;
   localparam logic [CTRL_W-1:0] M_COUT     = CTRL_W'(1) << C_COUT;
   localparam logic [CTRL_W-1:0] M_READ     = CTRL_W'(1) << C_READ;
   localparam logic [CTRL_W-1:0] M_WRITE    = CTRL_W'(1) << C_WRITE;

   // Opcode field values (IR[31:27])
   localparam logic [4:0] OP_LD        = 5'b00000;
   localparam logic [4:0] OP_ST        = 5'b00010;
   localparam logic [4:0] OP_ADD       = 5'b00011;
   localparam logic [4:0] OP_ALU3_LAST = 5'b01010;
   localparam logic [4:0] OP_MUL       = 5'b01110;
   localparam logic [4:0] OP_DIV       = 5'b01111;
   localparam logic [4:0] OP_NEG       = 5'b10000;
   localparam logic [4:0] OP_NOT       = 5'b10001;
   localparam logic [4:0] OP_NOP       = 5'b11001;
   localparam logic [4:0] OP_HALT      = 5'b11010;

   // Sequencer steps
   typedef enum logic [3:0] {
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_e;

   // Instruction classes produced by the decoder
   typedef enum logic [2:0] {
      CLS_ALU3, CLS_UNARY, CLS_LD, CLS_ST, CLS_MULDIV, CLS_NOP, CLS_HALT
   } instr_class_e;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - opcode to instruction-class decoder; CONTROL_UNIT_MULDIV_EN maps mul/div to MULDIV
module cu_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0]   op_i,
   output instr_class_e cls_o
);

   // Classify the opcode; anything not recognised runs as a nop
   always_comb begin
      cls_o = CLS_NOP;
      if (op_i == OP_LD) begin
         cls_o = CLS_LD;
      end else if (op_i == OP_ST) begin
         cls_o = CLS_ST;
      end else if ((op_i >= OP_ADD) && (op_i <= OP_ALU3_LAST)) begin
         cls_o = CLS_ALU3;
      end else if ((op_i == OP_NEG) || (op_i == OP_NOT)) begin
         cls_o = CLS_UNARY;
`ifdef CONTROL_UNIT_MULDIV_EN
      end else if ((op_i == OP_MUL) || (op_i == OP_DIV)) begin
         cls_o = CLS_MULDIV;
`endif
      end else if (op_i == OP_HALT) begin
         cls_o = CLS_HALT;
      end
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore fetch/execute sequencer; CONTROL_UNIT_MULDIV_EN enables the mul/div sequence
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic              Clock,
   input  logic              clear,
   input  logic [31:0]       IR,
   input  logic              mem_ready,
   output logic [CTRL_W-1:0] ctrl,
   output logic [4:0]        opcode,
   output logic              Run
);

   state_e       state_q, state_d;
   logic         run_q;
   instr_class_e cls;
   logic [4:0]   ir_op;
   logic         unused_ir;

   assign ir_op     = IR[31:27];
   assign unused_ir = ^IR[26:0];

   cu_decode u_decode (
      .op_i  (ir_op),
      .cls_o (cls)
   );

   // State register; run_q keeps the reset-exit cycle at T0 with strobes off
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_T0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   assign Run = run_q & (state_q != S_HALT);

   // Next-state and Moore outputs from the present step and instruction class
   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      opcode  = '0;
      if (!run_q) begin
         state_d = S_T0;
      end else begin
         case (state_q)
            S_T0: begin
               ctrl    = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
               state_d = S_T1;
            end
            S_T1: begin
               ctrl = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
               if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
               ctrl    = M_MDROUT | M_IRIN;
               state_d = S_T3;
            end
            S_T3: begin
               state_d = S_T4;
               case (cls)
                  CLS_ALU3:  ctrl = M_GRB | M_ROUT | M_YIN;
                  CLS_UNARY: begin
                     ctrl   = M_GRB | M_ROUT | M_ZIN;
                     opcode = ir_op;
                  end
                  CLS_LD, CLS_ST: ctrl = M_GRB | M_BAOUT | M_YIN;
`ifdef CONTROL_UNIT_MULDIV_EN
                  CLS_MULDIV: ctrl = M_GRA | M_ROUT | M_YIN;
`endif
                  CLS_HALT: state_d = S_HALT;
                  default:  state_d = S_T0;
               endcase
            end
            S_T4: begin
               state_d = S_T5;
               case (cls)
                  CLS_ALU3: begin
                     ctrl   = M_GRC | M_ROUT | M_ZIN;
                     opcode = ir_op;
                  end
                  CLS_UNARY: begin
                     ctrl    = M_ZLOWOUT | M_GRA | M_RIN;
                     state_d = S_T0;
                  end
                  CLS_LD, CLS_ST: begin
                     ctrl   = M_COUT | M_ZIN;
                     opcode = OP_ADD;
                  end
`ifdef CONTROL_UNIT_MULDIV_EN
                  CLS_MULDIV: begin
                     ctrl   = M_GRB | M_ROUT | M_ZIN;
                     opcode = ir_op;
                  end
`endif
                  default: state_d = S_T0;
               endcase
            end
            S_T5: begin
               state_d = S_T6;
               case (cls)
                  CLS_ALU3: begin
                     ctrl    = M_ZLOWOUT | M_GRA | M_RIN;
                     state_d = S_T0;
                  end
                  CLS_LD, CLS_ST: ctrl = M_ZLOWOUT | M_MARIN;
`ifdef CONTROL_UNIT_MULDIV_EN
                  CLS_MULDIV: ctrl = M_ZLOWOUT | M_LOIN;
`endif
                  default: state_d = S_T0;
               endcase
            end
            S_T6: begin
               state_d = S_T0;
               case (cls)
                  CLS_LD: begin
                     ctrl    = M_READ | M_MDRIN;
                     state_d = mem_ready ? S_T7 : S_T6;
                  end
                  CLS_ST: begin
                     ctrl    = M_GRA | M_ROUT | M_MDRIN;
                     state_d = S_T7;
                  end
`ifdef CONTROL_UNIT_MULDIV_EN
                  CLS_MULDIV: ctrl = M_ZHIGHOUT | M_HIIN;
`endif
                  default: state_d = S_T0;
               endcase
            end
            S_T7: begin
               state_d = S_T0;
               case (cls)
                  CLS_LD: ctrl = M_MDROUT | M_GRA | M_RIN;
                  CLS_ST: begin
                     ctrl    = M_WRITE;
                     state_d = mem_ready ? S_T0 : S_T7;
                  end
                  default: state_d = S_T0;
               endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_T0;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against a step-table model
module tb_control_unit;
   import cpu_ctrl_pkg::*;

`ifdef CONTROL_UNIT_MULDIV_EN
   localparam bit MULDIV_EN = 1'b1;
`else
   localparam bit MULDIV_EN = 1'b0;
`endif

   logic              Clock = 1'b0;
   logic              clear;
   logic [31:0]       IR;
   logic              mem_ready;
   logic [CTRL_W-1:0] ctrl;
   logic [4:0]        opcode;
   logic              Run;

   int errors  = 0;
   int checks  = 0;
   int n_instr = 0;

   // Expected per-cycle trace of the current instruction
   logic [CTRL_W-1:0] exp_ctrl[$];
   logic [4:0]        exp_op[$];
   logic              exp_run[$];
   logic              exp_mr[$];

   always #5 Clock = ~Clock;

   control_unit dut (
      .Clock     (Clock),
      .clear     (clear),
      .IR        (IR),
      .mem_ready (mem_ready),
      .ctrl      (ctrl),
      .opcode    (opcode),
      .Run       (Run)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // A step that ignores mem_ready: drive a random value to show it is not sampled
   task automatic push1(input logic [CTRL_W-1:0] c, input logic [4:0] o, input logic r);
      exp_ctrl.push_back(c);
      exp_op.push_back(o);
      exp_run.push_back(r);
      exp_mr.push_back(1'($urandom_range(0, 1)));
   endtask

   // A memory step held for n extra cycles with mem_ready low, then released
   task automatic push_wait(input logic [CTRL_W-1:0] c, input int n);
      for (int i = 0; i <= n; i++) begin
         exp_ctrl.push_back(c);
         exp_op.push_back(5'd0);
         exp_run.push_back(1'b1);
         exp_mr.push_back(i == n);
      end
   endtask

   // Expand one instruction into its cycle-by-cycle strobe trace
   task automatic build(input logic [31:0] ir, input int w1, input int w2);
      logic [4:0] op;
      op = ir[31:27];
      exp_ctrl.delete(); exp_op.delete(); exp_run.delete(); exp_mr.delete();
      push1(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b1);
      push_wait(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, w1);
      push1(M_MDROUT | M_IRIN, 5'd0, 1'b1);
      if (op >= 5'd3 && op <= 5'd10) begin
         push1(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
         push1(M_GRC | M_ROUT | M_ZIN, op, 1'b1);
         push1(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1);
      end else if (op == 5'd16 || op == 5'd17) begin
         push1(M_GRB | M_ROUT | M_ZIN, op, 1'b1);
         push1(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1);
      end else if (op == 5'd0 || op == 5'd2) begin
         push1(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
         push1(M_COUT | M_ZIN, 5'd3, 1'b1);
         push1(M_ZLOWOUT | M_MARIN, 5'd0, 1'b1);
         if (op == 5'd0) begin
            push_wait(M_READ | M_MDRIN, w2);
            push1(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b1);
         end else begin
            push1(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1);
            push_wait(M_WRITE, w2);
         end
      end else if (MULDIV_EN && (op == 5'd14 || op == 5'd15)) begin
         push1(M_GRA | M_ROUT | M_YIN, 5'd0, 1'b1);
         push1(M_GRB | M_ROUT | M_ZIN, op, 1'b1);
         push1(M_ZLOWOUT | M_LOIN, 5'd0, 1'b1);
         push1(M_ZHIGHOUT | M_HIIN, 5'd0, 1'b1);
      end else if (op == 5'd26) begin
         push1('0, 5'd0, 1'b1);
         repeat (12) push1('0, 5'd0, 1'b0);
      end else begin
         push1('0, 5'd0, 1'b1);
      end
   endtask

   // Run one instruction from its T0 cycle; optionally pull clear low at step abort_at
   task automatic exec_instr(input logic [31:0] ir, input int w1, input int w2, input int abort_at);
      build(ir, w1, w2);
      IR = ir;
      for (int k = 0; k < exp_ctrl.size(); k++) begin
         check($sformatf("i%0d s%0d ctrl", n_instr, k), 32'(ctrl), 32'(exp_ctrl[k]));
         check($sformatf("i%0d s%0d opcode", n_instr, k), 32'(opcode), 32'(exp_op[k]));
         check($sformatf("i%0d s%0d Run", n_instr, k), 32'(Run), 32'(exp_run[k]));
         if (k == abort_at) begin
            clear = 1'b0;
            #1;
            check($sformatf("i%0d abort ctrl", n_instr), 32'(ctrl), 32'd0);
            check($sformatf("i%0d abort opcode", n_instr), 32'(opcode), 32'd0);
            check($sformatf("i%0d abort Run", n_instr), 32'(Run), 32'd0);
            repeat (2) begin
               mem_ready = 1'($urandom_range(0, 1));
               @(negedge Clock);
               check($sformatf("i%0d held ctrl", n_instr), 32'(ctrl), 32'd0);
               check($sformatf("i%0d held Run", n_instr), 32'(Run), 32'd0);
            end
            clear = 1'b1;
            @(negedge Clock);
            n_instr++;
            return;
         end
         mem_ready = exp_mr[k];
         @(negedge Clock);
      end
      n_instr++;
   endtask

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0]  op;
      logic [31:0] ir;
      clear     = 1'b0;
      IR        = 32'd0;
      mem_ready = 1'b0;
      repeat (3) begin
         @(negedge Clock);
         check("reset ctrl", 32'(ctrl), 32'd0);
         check("reset opcode", 32'(opcode), 32'd0);
         check("reset Run", 32'(Run), 32'd0);
         mem_ready = 1'($urandom_range(0, 1));
      end
      clear = 1'b1;
      @(negedge Clock);

      exec_instr(32'h18918000, 0, 0, -1);   // add R1,R2,R3
      exec_instr(32'h80900000, 0, 0, -1);   // neg R1,R2
      exec_instr(32'h00880010, 0, 3, -1);   // ld with three wait cycles
      exec_instr(32'h10880010, 0, 0, -1);   // st zero wait
      exec_instr(32'h70900000, 0, 0, -1);   // mul
      exec_instr(32'h78900000, 1, 0, -1);   // div with fetch wait
      exec_instr(32'hC8000000, 0, 0, -1);   // nop
      exec_instr(32'hF8000000, 0, 0, -1);   // illegal 11111
      exec_instr(32'h88900000, 2, 0, -1);   // not with fetch waits

      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd26) op = 5'd25;
         ir = {op, 27'($urandom)};
         exec_instr(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      end

      // st with a long write wait; clear hits during the third T7 cycle (step 9)
      exec_instr(32'h10880010, 0, 5, 9);
      exec_instr(32'h18918000, 0, 0, -1);

      exec_instr(32'hD0000000, 0, 0, -1);   // halt
      clear = 1'b0;
      @(negedge Clock);
      check("post-halt reset ctrl", 32'(ctrl), 32'd0);
      clear = 1'b1;
      @(negedge Clock);
      exec_instr(32'hC8000000, 0, 0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
